data_mem_io: RTL

DATA_MEM_IO -- requirements
Module: data_mem_io

---
 rtl/data_mem_io_if.sv | 11 +
 rtl/data_mem_io.sv | 124 ++++++++++++
 2 files changed

// File: rtl/data_mem_io_if.sv
// CPU load/store address and direction for data_mem_io.
// The DD data bus stays a top-level inout so the tristate driver sits at the pin.
interface data_mem_io_if;
    localparam int unsigned AW = 16;

    logic [AW-1:0] da;
    logic          rw;

    modport master (output da, output rw);
    modport slave  (input  da, input  rw);
endinterface

// File: rtl/data_mem_io.sv
// Data-side memory and I/O: word RAM, OUT/IN ports and an optional timer.
// Build with DATA_MEM_TIMER_EN defined to include the TCNT/TCTL timer.
module data_mem_io #(
    parameter int unsigned RAM_AW  = 10,
    parameter int unsigned IN_SYNC = 2
) (
    input  logic         ck,
    input  logic         rst,
    data_mem_io_if.slave bus,
    inout  wire  [15:0]  dd,
    input  logic [15:0]  inp,
    output logic [15:0]  outp,
    output logic         tmr_irq
);
    localparam int unsigned DW        = 16;
    localparam int unsigned RAM_WORDS = 2 ** RAM_AW;
    localparam logic [DW-1:0] ADDR_OUT  = 16'hFF00;
    localparam logic [DW-1:0] ADDR_IN   = 16'hFF01;
    localparam logic [DW-1:0] ADDR_TCNT = 16'hFF02;
    localparam logic [DW-1:0] ADDR_TCTL = 16'hFF03;

    logic [DW-1:0]     mem [RAM_WORDS];
    logic [DW-1:0]     out_q;
    logic [DW-1:0]     sync_q [IN_SYNC];
    logic [DW-1:0]     rdata_c;
    logic              wr_c;
    logic              ram_hit_c;
    logic [RAM_AW-1:0] ram_idx_c;

    assign wr_c      = !bus.rw;
    assign ram_hit_c = (32'(bus.da) >> RAM_AW) == 32'd0;
    assign ram_idx_c = bus.da[RAM_AW-1:0];

    // RAM is deliberately not reset.
    always_ff @(posedge ck) begin
        if (wr_c && ram_hit_c) begin
            mem[ram_idx_c] <= dd;
        end
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            out_q <= '0;
        end else if (wr_c && bus.da == ADDR_OUT) begin
            out_q <= dd;
        end
    end

    // INP is asynchronous; only the last stage is ever observed.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < IN_SYNC; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= inp;
            for (int unsigned i = 1; i < IN_SYNC; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

`ifdef DATA_MEM_TIMER_EN
    logic [DW-1:0] tcnt_q;
    logic          tctl_en_q;
    logic          tctl_ovf_q;
    logic          wr_tcnt_c;
    logic          wr_tctl_c;
    logic          wrap_c;

    assign wr_tcnt_c = wr_c && bus.da == ADDR_TCNT;
    assign wr_tctl_c = wr_c && bus.da == ADDR_TCTL;
    // A TCNT write suppresses that cycle's increment, so it cannot wrap.
    assign wrap_c    = tctl_en_q && !wr_tcnt_c && tcnt_q == 16'hFFFF;

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            tcnt_q     <= '0;
            tctl_en_q  <= 1'b0;
            tctl_ovf_q <= 1'b0;
        end else begin
            if (wr_tcnt_c) begin
                tcnt_q <= dd;
            end else if (tctl_en_q) begin
                tcnt_q <= tcnt_q + 16'd1;
            end
            if (wr_tctl_c) begin
                tctl_en_q <= dd[0];
            end
            // Overflow set beats a same-cycle write-1-to-clear.
            if (wrap_c) begin
                tctl_ovf_q <= 1'b1;
            end else if (wr_tctl_c && dd[1]) begin
                tctl_ovf_q <= 1'b0;
            end
        end
    end

    assign tmr_irq = tctl_ovf_q;
`else
    assign tmr_irq = 1'b0;
`endif

    // Zero-latency read decode; unmapped addresses read as zero.
    always_comb begin
        rdata_c = '0;
        if (ram_hit_c) begin
            rdata_c = mem[ram_idx_c];
        end else begin
            case (bus.da)
                ADDR_OUT:  rdata_c = out_q;
                ADDR_IN:   rdata_c = sync_q[IN_SYNC-1];
`ifdef DATA_MEM_TIMER_EN
                ADDR_TCNT: rdata_c = tcnt_q;
                ADDR_TCTL: rdata_c = {14'b0, tctl_ovf_q, tctl_en_q};
`endif
                default:   rdata_c = '0;
            endcase
        end
    end

    assign dd   = bus.rw ? rdata_c : {DW{1'bz}};
    assign outp = out_q;
endmodule
